seq_reg_top: RTL and testbench
==============================

// Module: seq_reg_top
// PURPOSE
//   Self-running fixed-program sequencer with four 8-bit result registers a..d.
//   After reset it loads b, idles briefly, counts c up to b+1, then steps a up to a limit, and halts.
//   Top level of the generated-design regression; there are no inputs besides clock and reset.
// PARAMETERS
//   B_INIT       8'd48  value loaded into b in the INIT state
//   WAIT_CYCLES  3      number of idle cycles spent in the WAIT state
//   A_STEP       8'd3   increment applied to a per cycle in RUN_A
//   A_LIMIT      8'd36  RUN_A ends on the cycle a becomes >= A_LIMIT
// PORTS
//   clk  in   1  sole clock; all registers update on the rising edge
//   rst  in   1  asynchronous, active-low reset (asserted when 0)
//   a    out  8  result register a
//   b    out  8  result register b
//   c    out  8  result register c
//   d    out  8  debug/status register; constant 0 unless the optional feature is enabled
// BEHAVIOUR
//   - Reset (rst==0, async): a=b=c=d=0; state=INIT. Outputs are driven directly from registers.
//   - FSM states: INIT -> WAIT -> RUN_C -> RUN_A -> DONE. Each state is one or more full clock cycles.
//   - INIT (1 cycle): b<=B_INIT; next state WAIT.
//   - WAIT: a, c held; an internal counter counts WAIT_CYCLES cycles, then the FSM moves to RUN_C.
//   - RUN_C: c<=c+1 each cycle. When the incremented value equals b+1 (49), the FSM moves to RUN_A.
//     For these parameter values RUN_C lasts 49 cycles.
//   - RUN_A: a<=a+A_STEP each cycle. When the new a is >= A_LIMIT, the FSM moves to DONE.
//     For these parameter values RUN_A lasts 12 cycles and a ends at 36.
//   - DONE: all registers hold indefinitely; exit only through reset.
//   - Timeline (cycle 1 = first rising edge with rst high):
//     b=48 at cycle 1; c rises over cycles 5..53 to 49; a rises over cycles 54..65 to 36.
//   - Arithmetic: 8-bit modulo; compares are unsigned. The b+1 compare is done in 9 bits.
//   - b is written only in INIT. No register is written in WAIT or DONE.
//   - Reset mid-operation: async clear of all registers; the sequence restarts from INIT
//     on the first edge after release.
// CONFIGURATION
//   SEQ_REG_TOP_DBG_STATE_EN
//     defined:   d[2:0] = state code (INIT=0, WAIT=1, RUN_C=2, RUN_A=3, DONE=4); d[7:3]=0.
//                d updates with the state register and is 0 during reset.
//     undefined: d is tied to 8'd0. This is the regression configuration.
// STRUCTURE
//   - Package seq_reg_pkg: state enum (3-bit codes above) and default constants
//     B_INIT, WAIT_CYCLES, A_STEP, A_LIMIT.
//   - One sub-module seq_reg_ctrl: FSM plus WAIT counter. It emits the strobes ld_b, inc_c, inc_a
//     and the current state.
//   - The datapath registers a, b, c, d live in seq_reg_top.
// TESTING (macro undefined unless noted)
//   1. Hold rst=0 for 1 cycle, then release.
//      After 3 cycles: a=0, b=48, c=0, d=0.
//   2. 76 cycles after release: a=36, b=48, c=49, d=0.
//      Values are still unchanged 99 cycles later.
//   3. Sample c each cycle during RUN_C: strictly +1 per cycle, 1..49 with no gaps; a stays 0.
//   4. Assert rst=0 while RUN_C is active (c around 20):
//      all outputs are 0 immediately, without waiting for clk.
//      After release, the full sequence repeats with identical timing.
//   5. Sample a during RUN_A: 3, 6, ..., 36 (12 values); then constant; c holds 49.
//   6. With SEQ_REG_TOP_DBG_STATE_EN defined: d walks 0 -> 1 -> 2 -> 3 -> 4 and holds 4 in DONE.

Source files
------------

// File: rtl/seq_reg_pkg.sv
// Shared state encoding and fixed program constants for the seq_reg sequencer.
package seq_reg_pkg;

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_WAIT  = 3'd1,
    ST_RUN_C = 3'd2,
    ST_RUN_A = 3'd3,
    ST_DONE  = 3'd4
  } seq_state_e;

  localparam logic [7:0]  B_INIT      = 8'd48;
  localparam int unsigned WAIT_CYCLES = 3;
  localparam logic [7:0]  A_STEP      = 8'd3;
  localparam logic [7:0]  A_LIMIT     = 8'd36;

  localparam int unsigned WAIT_W    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_CYCLES - 1);

endpackage

// File: rtl/seq_reg_ctrl.sv
// Sequencer FSM and WAIT counter; decodes per-state datapath strobes.
// With SEQ_REG_TOP_DBG_STATE_EN defined the current state is also exported.
module seq_reg_ctrl
  import seq_reg_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [7:0] c,
  output logic       ld_b,
  output logic       inc_c,
  output logic       inc_a
`ifdef SEQ_REG_TOP_DBG_STATE_EN
  ,
  output seq_state_e state
`endif
);

  seq_state_e        state_q;
  logic [WAIT_W-1:0] wait_cnt;
  logic [8:0]        c_inc9;
  logic [8:0]        b_inc9;
  logic [7:0]        a_nxt;

  // Exit tests look at the value the datapath is writing this cycle.
  assign c_inc9 = {1'b0, c} + 9'd1;
  assign b_inc9 = {1'b0, b} + 9'd1;
  assign a_nxt  = a + A_STEP;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_INIT;
      wait_cnt <= '0;
    end else begin
      case (state_q)
        ST_INIT: begin
          state_q  <= ST_WAIT;
          wait_cnt <= '0;
        end
        ST_WAIT: begin
          if (wait_cnt == WAIT_LAST) state_q <= ST_RUN_C;
          else                       wait_cnt <= wait_cnt + WAIT_W'(1);
        end
        ST_RUN_C: if (c_inc9 == b_inc9)  state_q <= ST_RUN_A;
        ST_RUN_A: if (a_nxt >= A_LIMIT)  state_q <= ST_DONE;
        ST_DONE:  state_q <= ST_DONE;
        default:  state_q <= ST_INIT;
      endcase
    end
  end

  assign ld_b  = (state_q == ST_INIT);
  assign inc_c = (state_q == ST_RUN_C);
  assign inc_a = (state_q == ST_RUN_A);

`ifdef SEQ_REG_TOP_DBG_STATE_EN
  assign state = state_q;
`endif

endmodule

// File: rtl/seq_reg_top.sv
// Fixed-program sequencer top: result registers a, b, c and status d.
// Define SEQ_REG_TOP_DBG_STATE_EN to expose the FSM state code on d[2:0].
module seq_reg_top
  import seq_reg_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] a,
  output logic [7:0] b,
  output logic [7:0] c,
  output logic [7:0] d
);

  logic ld_b;
  logic inc_c;
  logic inc_a;

`ifdef SEQ_REG_TOP_DBG_STATE_EN
  seq_state_e state;
`endif

  seq_reg_ctrl u_ctrl (
    .clk   (clk),
    .rst   (rst),
    .a     (a),
    .b     (b),
    .c     (c),
    .ld_b  (ld_b),
    .inc_c (inc_c),
    .inc_a (inc_a)
`ifdef SEQ_REG_TOP_DBG_STATE_EN
    ,
    .state (state)
`endif
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a <= '0;
      b <= '0;
      c <= '0;
    end else begin
      if (ld_b)  b <= B_INIT;
      if (inc_c) c <= c + 8'd1;
      if (inc_a) a <= a + A_STEP;
    end
  end

`ifdef SEQ_REG_TOP_DBG_STATE_EN
  // State register resets to INIT (code 0), so d reads 0 during reset.
  assign d = {5'd0, state};
`else
  assign d = '0;
`endif

endmodule

// File: tb/tb_seq_reg_top.sv
// Self-checking bench for seq_reg_top: timeline model, vector table, random mid-run reset.
module tb_seq_reg_top;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] a, b, c, d;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  seq_reg_top dut (
    .clk (clk),
    .rst (rst),
    .a   (a),
    .b   (b),
    .c   (c),
    .d   (d)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned cyc;
    logic [7:0]  ea;
    logic [7:0]  eb;
    logic [7:0]  ec;
  } vec_t;

  localparam int unsigned NVEC = 10;
  vec_t vecs [NVEC];

  // Expected d after k edges since release (state code, or 0 in the default build).
  function automatic logic [7:0] exp_d(int unsigned k);
`ifdef SEQ_REG_TOP_DBG_STATE_EN
    if (k == 0)  return 8'd0;
    if (k <= 3)  return 8'd1;
    if (k <= 52) return 8'd2;
    if (k <= 64) return 8'd3;
    return 8'd4;
`else
    return (k > 0) ? 8'd0 : 8'd0;
`endif
  endfunction

  // Reference timeline: b set on edge 1, c counts on edges 5..53, a steps on edges 54..65.
  function automatic logic [31:0] model(int unsigned k);
    int unsigned ea, eb, ec, na;
    eb = (k >= 1) ? 48 : 0;
    ec = (k <= 4) ? 0 : (((k - 4) > 49) ? 49 : (k - 4));
    na = (k <= 53) ? 0 : (((k - 53) > 12) ? 12 : (k - 53));
    ea = 3 * na;
    return {8'(ea), 8'(eb), 8'(ec), exp_d(k)};
  endfunction

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [31:0] e);
    check8({tag, " a"}, a, e[31:24]);
    check8({tag, " b"}, b, e[23:16]);
    check8({tag, " c"}, c, e[15:8]);
    check8({tag, " d"}, d, e[7:0]);
  endtask

  // Run ncyc edges from release, checking every cycle against the model and the table.
  task automatic run_seq(input int unsigned ncyc, input string tag);
    int unsigned vi;
    logic [7:0]  prev_c;
    vi     = 0;
    prev_c = 8'd0;
    for (int unsigned k = 1; k <= ncyc; k++) begin
      @(posedge clk);
      #1;
      check_all($sformatf("%s cyc%0d", tag, k), model(k));
      if (k >= 5 && k <= 53)
        check8($sformatf("%s c_step cyc%0d", tag, k), c, 8'(prev_c + 8'd1));
      while (vi < NVEC && vecs[vi].cyc == k) begin
        check8($sformatf("%s vec%0d a", tag, vi), a, vecs[vi].ea);
        check8($sformatf("%s vec%0d b", tag, vi), b, vecs[vi].eb);
        check8($sformatf("%s vec%0d c", tag, vi), c, vecs[vi].ec);
        check8($sformatf("%s vec%0d d", tag, vi), d, exp_d(k));
        vi++;
      end
      prev_c = c;
    end
  endtask

  initial begin
    int unsigned r_cyc;
    int unsigned h_cyc;

    vecs[0] = '{cyc: 1,   ea: 8'd0,  eb: 8'd48, ec: 8'd0};
    vecs[1] = '{cyc: 3,   ea: 8'd0,  eb: 8'd48, ec: 8'd0};
    vecs[2] = '{cyc: 4,   ea: 8'd0,  eb: 8'd48, ec: 8'd0};
    vecs[3] = '{cyc: 5,   ea: 8'd0,  eb: 8'd48, ec: 8'd1};
    vecs[4] = '{cyc: 53,  ea: 8'd0,  eb: 8'd48, ec: 8'd49};
    vecs[5] = '{cyc: 54,  ea: 8'd3,  eb: 8'd48, ec: 8'd49};
    vecs[6] = '{cyc: 64,  ea: 8'd33, eb: 8'd48, ec: 8'd49};
    vecs[7] = '{cyc: 65,  ea: 8'd36, eb: 8'd48, ec: 8'd49};
    vecs[8] = '{cyc: 76,  ea: 8'd36, eb: 8'd48, ec: 8'd49};
    vecs[9] = '{cyc: 175, ea: 8'd36, eb: 8'd48, ec: 8'd49};

    // Reset held for one cycle
    rst = 1'b0;
    @(negedge clk);
    check_all("reset", 32'd0);
    rst = 1'b1;

    run_seq(175, "run1");

    // Second pass: random reset while c is around 20
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    r_cyc = $urandom_range(28, 22);
    run_seq(r_cyc, "pre_rst");
    #2;
    rst = 1'b0;
    #1;
    check_all("async_rst", 32'd0);
    h_cyc = $urandom_range(3, 1);
    repeat (h_cyc) @(negedge clk);
    check_all("rst_hold", 32'd0);
    rst = 1'b1;

    run_seq(180, "rerun");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
